// File: rtl/pipe_stage_skid_if.sv
// Handshake and bus bundle for pipe_stage_skid: upstream push side, downstream pop side,
// flush and stall counter. The stage itself uses the slave modport.
interface pipe_stage_skid_if #(
  parameter int unsigned CTRL_W = 3,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic [RD_W-1:0]   in_rd;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [RD_W-1:0]   out_rd;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output in_valid, in_ctrl, in_data, in_rd, flush, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, out_rd, stall_cnt
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, in_rd, flush, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, out_rd, stall_cnt
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline stage register with a two-entry skid buffer (main + skid),
// registered ready, flush/bubble gating of control bits and a saturating stall counter.
module pipe_stage_skid #(
  parameter int unsigned CTRL_W          = 3,
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned RD_W            = 5,
  parameter bit          FLUSH_ZERO_DATA = 1'b1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stage_skid_if.slave bus
);

  logic              r_m_valid;
  logic [CTRL_W-1:0] r_m_ctrl;
  logic [DATA_W-1:0] r_m_data;
  logic [RD_W-1:0]   r_m_rd;
  logic              r_s_valid;
  logic [CTRL_W-1:0] r_s_ctrl;
  logic [DATA_W-1:0] r_s_data;
  logic [RD_W-1:0]   r_s_rd;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_push;
  logic w_pop;

  // Ready is the inverse of skid occupancy, so it never depends on out_ready.
  assign w_push = bus.in_valid & ~r_s_valid;
  assign w_pop  = r_m_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid   <= 1'b0;
      r_m_ctrl    <= '0;
      r_m_data    <= '0;
      r_m_rd      <= '0;
      r_s_valid   <= 1'b0;
      r_s_ctrl    <= '0;
      r_s_data    <= '0;
      r_s_rd      <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (r_m_valid && !bus.out_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end

      if (bus.flush) begin
        r_m_valid <= 1'b0;
        r_s_valid <= 1'b0;
        r_m_ctrl  <= '0;
        r_s_ctrl  <= '0;
        if (FLUSH_ZERO_DATA) begin
          r_m_data <= '0;
          r_m_rd   <= '0;
          r_s_data <= '0;
          r_s_rd   <= '0;
        end
      end else if (!r_m_valid) begin
        if (w_push) begin
          r_m_valid <= 1'b1;
          r_m_ctrl  <= bus.in_ctrl;
          r_m_data  <= bus.in_data;
          r_m_rd    <= bus.in_rd;
        end
      end else if (!r_s_valid) begin
        if (w_pop && w_push) begin
          r_m_ctrl <= bus.in_ctrl;
          r_m_data <= bus.in_data;
          r_m_rd   <= bus.in_rd;
        end else if (w_pop) begin
          r_m_valid <= 1'b0;
        end else if (w_push) begin
          r_s_valid <= 1'b1;
          r_s_ctrl  <= bus.in_ctrl;
          r_s_data  <= bus.in_data;
          r_s_rd    <= bus.in_rd;
        end
      end else if (w_pop) begin
        r_m_ctrl  <= r_s_ctrl;
        r_m_data  <= r_s_data;
        r_m_rd    <= r_s_rd;
        r_s_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = ~r_s_valid;
  assign bus.out_valid = r_m_valid;
  assign bus.out_ctrl  = r_m_valid ? r_m_ctrl : '0;
  assign bus.out_data  = r_m_data;
  assign bus.out_rd    = r_m_rd;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: the stage is modelled as a FIFO of capacity two,
// items are queued on acceptance and a negedge monitor compares the head against the outputs.
module tb_pipe_stage_skid;

  localparam int unsigned CTRL_W = 3;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
    logic [RD_W-1:0]   r;
  } item_t;

  logic clk;
  logic rst;

  pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(CNT_W)) bus ();

  pipe_stage_skid #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .RD_W(RD_W),
    .FLUSH_ZERO_DATA(1'b1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  item_t       exp_q[$];
  int unsigned exp_cnt;
  int          n_checks;
  int          n_fail;
  logic        pend_push;
  logic        pend_flush;
  item_t       pend_item;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are stable at the falling edge; the head leaves if out_ready is high.
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() > 0));
      chk("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < 2));
      chk("stall_cnt", 64'(bus.stall_cnt), 64'(exp_cnt));
      if (exp_q.size() > 0) begin
        chk("out_ctrl", 64'(bus.out_ctrl), 64'(exp_q[0].c));
        chk("out_data", bus.out_data, exp_q[0].d);
        chk("out_rd", 64'(bus.out_rd), 64'(exp_q[0].r));
        if (bus.out_ready) void'(exp_q.pop_front());
        else if (exp_cnt < CNT_MAX) exp_cnt++;
      end else begin
        chk("bubble_ctrl", 64'(bus.out_ctrl), 64'd0);
      end
    end
  end

  // One clock cycle: commit what the previous edge did to the model, then drive new inputs.
  task automatic step(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                      input logic [RD_W-1:0] r, input logic ordy, input logic fl,
                      output logic acc);
    @(posedge clk);
    #1;
    if (pend_flush) exp_q.delete();
    else if (pend_push) exp_q.push_back(pend_item);
    bus.in_valid  = v;
    bus.in_ctrl   = c;
    bus.in_data   = d;
    bus.in_rd     = r;
    bus.out_ready = ordy;
    bus.flush     = fl;
    acc = v && (exp_q.size() < 2) && !fl;
    pend_push  = acc;
    pend_flush = fl;
    pend_item.c = c;
    pend_item.d = d;
    pend_item.r = r;
  endtask

  task automatic idle(input logic ordy);
    logic a;
    step(1'b0, '1, '0, '0, ordy, 1'b0, a);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    exp_cnt    = 0;
    pend_push  = 1'b0;
    pend_flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
    chk("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic acc;
    int   guard;
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 0;
    pend_push  = 1'b0;
    pend_flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_ctrl = '0; bus.in_data = '0; bus.in_rd = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b1;
    #2;
    do_reset();

    // Streaming with out_ready high
    step(1'b1, 3'b101, 64'h11, 5'd5, 1'b1, 1'b0, acc);
    step(1'b1, 3'b011, 64'h22, 5'd6, 1'b1, 1'b0, acc);
    @(negedge clk);
    chk("stream_a_data", bus.out_data, 64'h11);
    chk("stream_a_ctrl", 64'(bus.out_ctrl), 64'b101);
    idle(1'b1);
    @(negedge clk);
    chk("stream_b_data", bus.out_data, 64'h22);
    chk("stream_b_rd", 64'(bus.out_rd), 64'd6);
    chk("stream_in_ready", 64'(bus.in_ready), 64'd1);
    chk("stream_stall", 64'(bus.stall_cnt), 64'd0);
    idle(1'b1);

    // Back-pressure: A, B absorbed, C held upstream until skid drains
    do_reset();
    step(1'b1, 3'd1, 64'hA, 5'd1, 1'b0, 1'b0, acc);
    step(1'b1, 3'd2, 64'hB, 5'd2, 1'b0, 1'b0, acc);
    step(1'b1, 3'd3, 64'hC, 5'd3, 1'b0, 1'b0, acc);
    @(negedge clk);
    chk("bp_c_in_ready", 64'(bus.in_ready), 64'd0);
    step(1'b1, 3'd3, 64'hC, 5'd3, 1'b0, 1'b0, acc);
    guard = 0;
    acc = 1'b0;
    while (!acc && guard < 10) begin
      step(1'b1, 3'd3, 64'hC, 5'd3, 1'b1, 1'b0, acc);
      guard++;
    end
    chk("bp_c_accepted", 64'(acc), 64'd1);
    chk("bp_stall_cnt", 64'(bus.stall_cnt), 64'd3);
    idle(1'b1);
    idle(1'b1);

    // Flush with both entries full and an incoming item
    do_reset();
    step(1'b1, 3'd7, 64'h55, 5'd9, 1'b0, 1'b0, acc);
    step(1'b1, 3'd6, 64'h66, 5'd10, 1'b0, 1'b0, acc);
    step(1'b1, 3'd5, 64'h77, 5'd11, 1'b0, 1'b1, acc);
    idle(1'b1);
    @(negedge clk);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_out_ctrl", 64'(bus.out_ctrl), 64'd0);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    chk("flush_out_data", bus.out_data, 64'd0);
    chk("flush_out_rd", 64'(bus.out_rd), 64'd0);
    idle(1'b1);

    // Bubble gating
    idle(1'b0);
    @(negedge clk);
    chk("bubble_out_ctrl", 64'(bus.out_ctrl), 64'd0);
    chk("bubble_out_valid", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset mid-operation with both entries full
    step(1'b1, 3'd1, 64'h1234, 5'd1, 1'b0, 1'b0, acc);
    step(1'b1, 3'd2, 64'h5678, 5'd2, 1'b0, 1'b0, acc);
    @(posedge clk);
    #3;
    do_reset();
    step(1'b1, 3'd4, 64'h9ABC, 5'd17, 1'b1, 1'b0, acc);
    idle(1'b1);
    @(negedge clk);
    chk("post_rst_data", bus.out_data, 64'h9ABC);
    chk("post_rst_valid", 64'(bus.out_valid), 64'd1);
    idle(1'b1);

    // Counter saturation
    do_reset();
    step(1'b1, 3'd1, 64'hF0, 5'd3, 1'b0, 1'b0, acc);
    for (int i = 0; i < 20; i++) idle(1'b0);
    @(negedge clk);
    chk("sat_stall_cnt", 64'(bus.stall_cnt), 64'(CNT_MAX));
    idle(1'b0);
    idle(1'b1);

    // Randomised traffic
    do_reset();
    for (int i = 0; i < 500; i++) begin
      logic [DATA_W-1:0] d;
      d = {$urandom, $urandom};
      step(1'($urandom_range(0, 2) != 0), 3'($urandom), d, 5'($urandom),
           1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 24) == 0), acc);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    @(negedge clk);
    chk("drain_empty", 64'(bus.out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
